buffered_io_interface: RTL and testbench
========================================

// Module: buffered_io_interface
// PURPOSE
//   Parametrised successor to the single-byte keyboard/VGA I/O glue. Sits between the
//   keyboard decoder and VGA character sink on one side and the CPU's INPR/OUTR/FGI/FGO
//   path on the other. Adds a FIFO in each direction, sticky overflow flags, optional
//   local echo of keystrokes to the display, and an IEN-gated interrupt request.
// PARAMETERS
//   DATA_W    8   width of one character (keyboard byte / OUTR byte)
//   IN_DEPTH  16  input FIFO entries; power of two, >= 2
//   OUT_DEPTH 16  output FIFO entries; power of two, >= 2
// PORTS
//   clock         in   1            system clock; all logic on its rising edge
//   io_clr_n      in   1            synchronous, active-low reset
//   kbd_data      in   DATA_W       byte from keyboard decoder, already in clock domain
//   kbd_valid     in   1            one-cycle strobe: kbd_data is valid
//   inpr_data     out  DATA_W       head of input FIFO (CPU INPR view)
//   fgi           out  1            input FIFO not empty
//   inp_ack       in   1            CPU consumed inpr_data (INP executed); pops one entry
//   outr_data     in   DATA_W       CPU OUTR byte
//   out_wr        in   1            CPU OUT strobe; pushes outr_data
//   fgo           out  1            output FIFO not full (CPU may write)
//   vga_data      out  DATA_W       head of output FIFO toward VGA sink
//   vga_valid     out  1            output FIFO not empty
//   vga_ready     in   1            sink accepts vga_data this cycle
//   echo_en       in   1            copy accepted keystrokes into output FIFO
//   ien           in   1            interrupt enable
//   irq           out  1            ien & (fgi | fgo)
//   in_ovf        out  1            sticky: keystroke dropped, input FIFO full
//   out_ovf       out  1            sticky: out_wr dropped, output FIFO full
//   ovf_clr       in   1            clears both sticky overflow flags
//   in_count      out  clog2(IN_DEPTH+1)   input FIFO occupancy
//   out_count     out  clog2(OUT_DEPTH+1)  output FIFO occupancy
// BEHAVIOUR
//   Reset (io_clr_n=0 at edge): both FIFOs emptied, pointers/counts 0; fgi=0, fgo=1,
//     vga_valid=0, in_ovf=0, out_ovf=0; inpr_data and vga_data 0; irq = ien.
//     Reset mid-transfer discards all buffered bytes; no partial state survives.
//   Status outputs registered from next-state: an event at edge N is visible after N.
//   Input FIFO: push = kbd_valid & (not full | pop this cycle); pop = inp_ack & fgi.
//     kbd_valid while full and no pop: byte dropped, in_ovf set.
//     inp_ack while empty: ignored; counts and pointers unchanged.
//     Push+pop when empty: pop ignored; push lands; fgi=1 after the edge.
//     Push+pop when full: both succeed; count stays IN_DEPTH; in_ovf unchanged.
//   Output FIFO: sources out_wr (priority) and echo.
//     echo push = echo_en & accepted kbd push & !out_wr & out FIFO not full (after pop).
//     A blocked echo is silently skipped; it never sets out_ovf.
//     out_wr while full and no vga pop: byte dropped, out_ovf set.
//     Pop = vga_valid & vga_ready; push+pop when full both succeed.
//   Handshake: vga_data is stable while vga_valid & !vga_ready; the next entry appears
//     the cycle after the pop edge. inpr_data behaves the same way w.r.t. inp_ack.
//   Pointers wrap modulo depth; count width clog2(DEPTH+1) holds DEPTH exactly.
//   ovf_clr and a same-cycle overflow event: the event wins and the flag stays 1.
//   irq is combinational from registered fgi/fgo and the ien input.
// TESTING
//   reset; kbd 0x41,0x42 -> fgi=1, inpr_data=0x41, in_count=2; inp_ack -> 0x42, count 1
//   17 kbd strobes, IN_DEPTH=16, no ack -> in_count=16, in_ovf=1, byte 17 lost; ovf_clr -> 0
//   out_wr 0x55 with vga_ready=0 for 5 cycles -> vga_data held at 0x55; ready=1 -> pop, valid=0
//   echo_en=1, kbd 0x61 and out_wr 0x30 in same cycle -> output FIFO holds only 0x30
//   full out FIFO, out_wr + vga_ready same cycle -> accepted, out_count=16, out_ovf=0
//   ien=1, fgo=1 -> irq=1; fill output FIFO with input FIFO empty -> irq=0; io_clr_n=0 -> all flushed

Source files
------------

// File: rtl/buffered_io_interface.sv
// rtl/buffered_io_interface.sv - keyboard/VGA glue with input and output FIFOs, echo, sticky overflow and IEN-gated irq
module buffered_io_interface #(
  parameter int DATA_W    = 8,
  parameter int IN_DEPTH  = 16,
  parameter int OUT_DEPTH = 16,
  localparam int IN_CW    = $clog2(IN_DEPTH + 1),
  localparam int OUT_CW   = $clog2(OUT_DEPTH + 1),
  localparam int IN_AW    = $clog2(IN_DEPTH),
  localparam int OUT_AW   = $clog2(OUT_DEPTH)
) (
  input  logic              clock,
  input  logic              io_clr_n,
  input  logic [DATA_W-1:0] kbd_data,
  input  logic              kbd_valid,
  output logic [DATA_W-1:0] inpr_data,
  output logic              fgi,
  input  logic              inp_ack,
  input  logic [DATA_W-1:0] outr_data,
  input  logic              out_wr,
  output logic              fgo,
  output logic [DATA_W-1:0] vga_data,
  output logic              vga_valid,
  input  logic              vga_ready,
  input  logic              echo_en,
  input  logic              ien,
  output logic              irq,
  output logic              in_ovf,
  output logic              out_ovf,
  input  logic              ovf_clr,
  output logic [IN_CW-1:0]  in_count,
  output logic [OUT_CW-1:0] out_count
);

  logic [DATA_W-1:0] in_mem  [IN_DEPTH];
  logic [DATA_W-1:0] out_mem [OUT_DEPTH];

  logic [IN_AW-1:0]  in_wr_q, in_wr_d, in_rd_q, in_rd_d;
  logic [OUT_AW-1:0] out_wr_q, out_wr_d, out_rd_q, out_rd_d;
  logic [IN_CW-1:0]  in_count_q, in_count_d;
  logic [OUT_CW-1:0] out_count_q, out_count_d;
  logic              fgi_q, fgi_d, fgo_q, fgo_d, vga_valid_q, vga_valid_d;
  logic              in_ovf_q, in_ovf_d, out_ovf_q, out_ovf_d;

  logic              in_full, in_pop, in_push, in_drop;
  logic              out_full, out_pop, out_space, out_push, out_drop, echo_push;
  logic [DATA_W-1:0] out_push_data;

  always_comb begin
    in_full   = (in_count_q == IN_CW'(IN_DEPTH));
    in_pop    = inp_ack & fgi_q;
    in_push   = kbd_valid & (~in_full | in_pop);
    in_drop   = kbd_valid & ~in_push;

    out_full  = (out_count_q == OUT_CW'(OUT_DEPTH));
    out_pop   = vga_valid_q & vga_ready;
    out_space = ~out_full | out_pop;
    // CPU writes take the slot; an echo only fills otherwise unused space
    echo_push = echo_en & in_push & ~out_wr & out_space;
    out_push  = (out_wr & out_space) | echo_push;
    out_drop  = out_wr & ~out_space;
    out_push_data = out_wr ? outr_data : kbd_data;

    in_wr_d     = in_push ? in_wr_q + IN_AW'(1) : in_wr_q;
    in_rd_d     = in_pop ? in_rd_q + IN_AW'(1) : in_rd_q;
    in_count_d  = in_count_q + IN_CW'(in_push) - IN_CW'(in_pop);
    out_wr_d    = out_push ? out_wr_q + OUT_AW'(1) : out_wr_q;
    out_rd_d    = out_pop ? out_rd_q + OUT_AW'(1) : out_rd_q;
    out_count_d = out_count_q + OUT_CW'(out_push) - OUT_CW'(out_pop);

    fgi_d       = (in_count_d != '0);
    fgo_d       = (out_count_d != OUT_CW'(OUT_DEPTH));
    vga_valid_d = (out_count_d != '0);
    in_ovf_d    = in_drop | (in_ovf_q & ~ovf_clr);
    out_ovf_d   = out_drop | (out_ovf_q & ~ovf_clr);
  end

  always_ff @(posedge clock) begin
    if (!io_clr_n) begin
      in_wr_q     <= '0;
      in_rd_q     <= '0;
      out_wr_q    <= '0;
      out_rd_q    <= '0;
      in_count_q  <= '0;
      out_count_q <= '0;
      fgi_q       <= 1'b0;
      fgo_q       <= 1'b1;
      vga_valid_q <= 1'b0;
      in_ovf_q    <= 1'b0;
      out_ovf_q   <= 1'b0;
    end else begin
      in_wr_q     <= in_wr_d;
      in_rd_q     <= in_rd_d;
      out_wr_q    <= out_wr_d;
      out_rd_q    <= out_rd_d;
      in_count_q  <= in_count_d;
      out_count_q <= out_count_d;
      fgi_q       <= fgi_d;
      fgo_q       <= fgo_d;
      vga_valid_q <= vga_valid_d;
      in_ovf_q    <= in_ovf_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  // Storage needs no reset: empty flags mask stale contents
  always_ff @(posedge clock) begin
    if (in_push)  in_mem[in_wr_q]   <= kbd_data;
    if (out_push) out_mem[out_wr_q] <= out_push_data;
  end

  assign inpr_data = fgi_q ? in_mem[in_rd_q] : '0;
  assign vga_data  = vga_valid_q ? out_mem[out_rd_q] : '0;
  assign fgi       = fgi_q;
  assign fgo       = fgo_q;
  assign vga_valid = vga_valid_q;
  assign in_ovf    = in_ovf_q;
  assign out_ovf   = out_ovf_q;
  assign in_count  = in_count_q;
  assign out_count = out_count_q;
  assign irq       = ien & (fgi_q | fgo_q);

endmodule

// File: tb/tb_buffered_io_interface.sv
// tb/tb_buffered_io_interface.sv - directed and randomized checks of buffered_io_interface against a queue model
module tb_buffered_io_interface;

  logic       clock = 1'b0;
  logic       io_clr_n = 1'b0;
  logic [7:0] kbd_data = '0;
  logic       kbd_valid = 1'b0;
  logic [7:0] inpr_data;
  logic       fgi;
  logic       inp_ack = 1'b0;
  logic [7:0] outr_data = '0;
  logic       out_wr = 1'b0;
  logic       fgo;
  logic [7:0] vga_data;
  logic       vga_valid;
  logic       vga_ready = 1'b0;
  logic       echo_en = 1'b0;
  logic       ien = 1'b0;
  logic       irq;
  logic       in_ovf;
  logic       out_ovf;
  logic       ovf_clr = 1'b0;
  logic [4:0] in_count;
  logic [4:0] out_count;

  int n_checks = 0;
  int n_fail = 0;

  logic [7:0] inq[$];
  logic [7:0] outq[$];
  logic       m_in_ovf = 1'b0;
  logic       m_out_ovf = 1'b0;

  buffered_io_interface #(.DATA_W(8), .IN_DEPTH(16), .OUT_DEPTH(16)) dut (
    .clock(clock), .io_clr_n(io_clr_n), .kbd_data(kbd_data), .kbd_valid(kbd_valid),
    .inpr_data(inpr_data), .fgi(fgi), .inp_ack(inp_ack), .outr_data(outr_data),
    .out_wr(out_wr), .fgo(fgo), .vga_data(vga_data), .vga_valid(vga_valid),
    .vga_ready(vga_ready), .echo_en(echo_en), .ien(ien), .irq(irq), .in_ovf(in_ovf),
    .out_ovf(out_ovf), .ovf_clr(ovf_clr), .in_count(in_count), .out_count(out_count)
  );

  always #5 clock = ~clock;

  // Reference: two bounded queues of 16, updated from the inputs seen before the edge
  task automatic model_step();
    bit ipop, ipush, opop, ospace;
    if (!io_clr_n) begin
      inq.delete();
      outq.delete();
      m_in_ovf = 1'b0;
      m_out_ovf = 1'b0;
    end else begin
      ipop   = inp_ack && inq.size() > 0;
      ipush  = kbd_valid && (inq.size() < 16 || ipop);
      opop   = vga_ready && outq.size() > 0;
      ospace = outq.size() < 16 || opop;
      if (ipop) void'(inq.pop_front());
      if (ipush) inq.push_back(kbd_data);
      if (opop) void'(outq.pop_front());
      if (out_wr && ospace) outq.push_back(outr_data);
      else if (echo_en && ipush && !out_wr && ospace) outq.push_back(kbd_data);
      m_in_ovf  = (kbd_valid && !ipush) ? 1'b1 : (ovf_clr ? 1'b0 : m_in_ovf);
      m_out_ovf = (out_wr && !ospace) ? 1'b1 : (ovf_clr ? 1'b0 : m_out_ovf);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
    kbd_valid = 1'b0;
    inp_ack = 1'b0;
    out_wr = 1'b0;
    ovf_clr = 1'b0;
  endtask

  task automatic do_reset();
    io_clr_n = 1'b0;
    tick();
    io_clr_n = 1'b1;
  endtask

  task automatic test_reset();
    ien = 1'b1;
    do_reset();
    n_checks++; if (fgi !== 1'b0) begin n_fail++; $display("FAIL reset_fgi: got %b expected 0", fgi); end
    n_checks++; if (fgo !== 1'b1) begin n_fail++; $display("FAIL reset_fgo: got %b expected 1", fgo); end
    n_checks++; if (vga_valid !== 1'b0) begin n_fail++; $display("FAIL reset_vga_valid: got %b expected 0", vga_valid); end
    n_checks++; if ({in_ovf, out_ovf} !== 2'b00) begin n_fail++; $display("FAIL reset_ovf: got %b%b expected 00", in_ovf, out_ovf); end
    n_checks++; if ({inpr_data, vga_data} !== 16'h0) begin n_fail++; $display("FAIL reset_data: got %h %h expected 00 00", inpr_data, vga_data); end
    n_checks++; if ({in_count, out_count} !== 10'h0) begin n_fail++; $display("FAIL reset_counts: got %0d %0d expected 0 0", in_count, out_count); end
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL reset_irq: got %b expected 1", irq); end
    ien = 1'b0;
  endtask

  task automatic test_input_basic();
    kbd_data = 8'h41; kbd_valid = 1'b1; tick();
    kbd_data = 8'h42; kbd_valid = 1'b1; tick();
    n_checks++; if (fgi !== 1'b1) begin n_fail++; $display("FAIL in_basic_fgi: got %b expected 1", fgi); end
    n_checks++; if (inpr_data !== 8'h41) begin n_fail++; $display("FAIL in_basic_head: got %h expected 41", inpr_data); end
    n_checks++; if (in_count !== 5'd2) begin n_fail++; $display("FAIL in_basic_count: got %0d expected 2", in_count); end
    inp_ack = 1'b1; tick();
    n_checks++; if (inpr_data !== 8'h42 || in_count !== 5'd1) begin n_fail++; $display("FAIL in_basic_pop: got %h/%0d expected 42/1", inpr_data, in_count); end
    inp_ack = 1'b1; tick();
    inp_ack = 1'b1; tick();
    n_checks++; if (in_count !== 5'd0 || fgi !== 1'b0) begin n_fail++; $display("FAIL in_empty_ack: got %0d/%b expected 0/0", in_count, fgi); end
    kbd_data = 8'h77; kbd_valid = 1'b1; inp_ack = 1'b1; tick();
    n_checks++; if (in_count !== 5'd1 || inpr_data !== 8'h77) begin n_fail++; $display("FAIL in_empty_pushpop: got %0d/%h expected 1/77", in_count, inpr_data); end
    do_reset();
  endtask

  task automatic test_input_overflow();
    logic [7:0] exp_b[16];
    for (int i = 0; i < 17; i++) begin
      kbd_data = 8'(8'h10 + i); kbd_valid = 1'b1; tick();
    end
    n_checks++; if (in_count !== 5'd16 || in_ovf !== 1'b1) begin n_fail++; $display("FAIL in_ovf_set: got %0d/%b expected 16/1", in_count, in_ovf); end
    ovf_clr = 1'b1; tick();
    n_checks++; if (in_ovf !== 1'b0) begin n_fail++; $display("FAIL in_ovf_clr: got %b expected 0", in_ovf); end
    kbd_data = 8'hEE; kbd_valid = 1'b1; inp_ack = 1'b1; tick();
    n_checks++; if (in_count !== 5'd16 || in_ovf !== 1'b0 || inpr_data !== 8'h11) begin n_fail++; $display("FAIL in_full_pushpop: got %0d/%b/%h expected 16/0/11", in_count, in_ovf, inpr_data); end
    kbd_data = 8'hEF; kbd_valid = 1'b1; ovf_clr = 1'b1; tick();
    n_checks++; if (in_ovf !== 1'b1) begin n_fail++; $display("FAIL in_ovf_clr_race: got %b expected 1", in_ovf); end
    for (int i = 0; i < 15; i++) exp_b[i] = 8'(8'h11 + i);
    exp_b[15] = 8'hEE;
    for (int i = 0; i < 16; i++) begin
      n_checks++; if (inpr_data !== exp_b[i]) begin n_fail++; $display("FAIL in_drain_%0d: got %h expected %h", i, inpr_data, exp_b[i]); end
      inp_ack = 1'b1; tick();
    end
    n_checks++; if (fgi !== 1'b0) begin n_fail++; $display("FAIL in_drain_empty: got %b expected 0", fgi); end
    do_reset();
  endtask

  task automatic test_vga_hold();
    vga_ready = 1'b0;
    outr_data = 8'h55; out_wr = 1'b1; tick();
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (vga_data !== 8'h55 || vga_valid !== 1'b1) begin n_fail++; $display("FAIL vga_hold_%0d: got %h/%b expected 55/1", i, vga_data, vga_valid); end
      tick();
    end
    vga_ready = 1'b1; tick();
    n_checks++; if (vga_valid !== 1'b0 || out_count !== 5'd0) begin n_fail++; $display("FAIL vga_pop: got %b/%0d expected 0/0", vga_valid, out_count); end
    vga_ready = 1'b0;
  endtask

  task automatic test_echo_priority();
    echo_en = 1'b1;
    kbd_data = 8'h61; kbd_valid = 1'b1; outr_data = 8'h30; out_wr = 1'b1; tick();
    n_checks++; if (out_count !== 5'd1 || vga_data !== 8'h30) begin n_fail++; $display("FAIL echo_prio: got %0d/%h expected 1/30", out_count, vga_data); end
    n_checks++; if (in_count !== 5'd1 || inpr_data !== 8'h61) begin n_fail++; $display("FAIL echo_prio_in: got %0d/%h expected 1/61", in_count, inpr_data); end
    kbd_data = 8'h62; kbd_valid = 1'b1; tick();
    n_checks++; if (out_count !== 5'd2) begin n_fail++; $display("FAIL echo_push: got %0d expected 2", out_count); end
    echo_en = 1'b0;
    do_reset();
  endtask

  task automatic test_out_full_pushpop();
    vga_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      outr_data = 8'(8'hA0 + i); out_wr = 1'b1; tick();
    end
    n_checks++; if (fgo !== 1'b0 || out_count !== 5'd16) begin n_fail++; $display("FAIL out_full: got %b/%0d expected 0/16", fgo, out_count); end
    outr_data = 8'hAA; out_wr = 1'b1; vga_ready = 1'b1; tick();
    vga_ready = 1'b0;
    n_checks++; if (out_count !== 5'd16 || out_ovf !== 1'b0 || vga_data !== 8'hA1) begin n_fail++; $display("FAIL out_full_pushpop: got %0d/%b/%h expected 16/0/a1", out_count, out_ovf, vga_data); end
    echo_en = 1'b1; kbd_data = 8'h33; kbd_valid = 1'b1; tick();
    echo_en = 1'b0;
    n_checks++; if (out_ovf !== 1'b0 || out_count !== 5'd16) begin n_fail++; $display("FAIL echo_blocked: got %b/%0d expected 0/16", out_ovf, out_count); end
    outr_data = 8'hBB; out_wr = 1'b1; tick();
    n_checks++; if (out_ovf !== 1'b1) begin n_fail++; $display("FAIL out_ovf_set: got %b expected 1", out_ovf); end
    do_reset();
  endtask

  task automatic test_irq();
    ien = 1'b1; #1;
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_fgo: got %b expected 1", irq); end
    for (int i = 0; i < 16; i++) begin
      outr_data = 8'(i); out_wr = 1'b1; tick();
    end
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_full: got %b expected 0", irq); end
    kbd_data = 8'h01; kbd_valid = 1'b1; tick();
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_fgi: got %b expected 1", irq); end
    ien = 1'b0; #1;
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_ien_off: got %b expected 0", irq); end
    do_reset();
    n_checks++; if (in_count !== 5'd0 || out_count !== 5'd0 || fgo !== 1'b1 || fgi !== 1'b0) begin n_fail++; $display("FAIL flush: got %0d/%0d/%b/%b expected 0/0/1/0", in_count, out_count, fgo, fgi); end
  endtask

  task automatic test_random();
    logic [7:0] e_in, e_out;
    for (int i = 0; i < 1500; i++) begin
      io_clr_n  = ($urandom_range(0, 199) != 0);
      kbd_data  = 8'($urandom);
      kbd_valid = ($urandom_range(0, 1) == 1);
      outr_data = 8'($urandom);
      out_wr    = ($urandom_range(0, 2) == 0);
      inp_ack   = ($urandom_range(0, 3) < ((i % 300) < 150 ? 1 : 3));
      vga_ready = ($urandom_range(0, 3) < ((i % 250) < 120 ? 1 : 3));
      ovf_clr   = ($urandom_range(0, 15) == 0);
      ien       = ($urandom_range(0, 1) == 1);
      if (i % 40 == 0) echo_en = ($urandom_range(0, 1) == 1);
      tick();
      e_in  = (inq.size() > 0) ? inq[0] : 8'h00;
      e_out = (outq.size() > 0) ? outq[0] : 8'h00;
      n_checks++; if (in_count !== 5'(inq.size())) begin n_fail++; $display("FAIL rnd_in_count @%0d: got %0d expected %0d", i, in_count, inq.size()); end
      n_checks++; if (out_count !== 5'(outq.size())) begin n_fail++; $display("FAIL rnd_out_count @%0d: got %0d expected %0d", i, out_count, outq.size()); end
      n_checks++; if (inpr_data !== e_in) begin n_fail++; $display("FAIL rnd_inpr @%0d: got %h expected %h", i, inpr_data, e_in); end
      n_checks++; if (vga_data !== e_out) begin n_fail++; $display("FAIL rnd_vga @%0d: got %h expected %h", i, vga_data, e_out); end
      n_checks++; if (fgi !== (inq.size() != 0)) begin n_fail++; $display("FAIL rnd_fgi @%0d: got %b expected %b", i, fgi, inq.size() != 0); end
      n_checks++; if (fgo !== (outq.size() != 16)) begin n_fail++; $display("FAIL rnd_fgo @%0d: got %b expected %b", i, fgo, outq.size() != 16); end
      n_checks++; if (vga_valid !== (outq.size() != 0)) begin n_fail++; $display("FAIL rnd_vga_valid @%0d: got %b expected %b", i, vga_valid, outq.size() != 0); end
      n_checks++; if (in_ovf !== m_in_ovf) begin n_fail++; $display("FAIL rnd_in_ovf @%0d: got %b expected %b", i, in_ovf, m_in_ovf); end
      n_checks++; if (out_ovf !== m_out_ovf) begin n_fail++; $display("FAIL rnd_out_ovf @%0d: got %b expected %b", i, out_ovf, m_out_ovf); end
      n_checks++; if (irq !== (ien && (inq.size() != 0 || outq.size() != 16))) begin n_fail++; $display("FAIL rnd_irq @%0d: got %b", i, irq); end
    end
    io_clr_n = 1'b1;
    echo_en = 1'b0;
    vga_ready = 1'b0;
  endtask

  initial begin
    @(posedge clock);
    #1;
    test_reset();
    test_input_basic();
    test_input_overflow();
    test_vga_hold();
    test_echo_priority();
    test_out_full_pushpop();
    test_irq();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
